programmable_trace_filter: RTL and testbench

//  Runtime-programmable successor of the branch/jump/WFI trace filter; sits between the CPU trace port and trace storage.

---
 rtl/programmable_trace_filter_if.sv | 36 +++
 rtl/programmable_trace_filter.sv | 206 ++++++++++++++++++++
 tb/tb_programmable_trace_filter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/programmable_trace_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : programmable_trace_filter_if
// Description : Trace-port bundle between the CPU trace source (master) and
//               the programmable trace filter (slave). The master presents one
//               retired instruction per cycle. The filter answers in the same
//               cycle with the keep/drop decision and the event flag.
//   pc_valid      master->slave  instruction/PC valid this cycle
//   pc            master->slave  PC of the instruction
//   instr         master->slave  instruction word (compressed in [15:0])
//   drop_instr    slave->master  1: discard the current instruction
//   event_hit     slave->master  current instruction is an enabled event
//   trail_active  slave->master  trail counter is non-zero (registered)
// Revision    : 1.0 - initial release
// ============================================================================
interface programmable_trace_filter_if #(
    parameter int XLEN = 64
) ();
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            drop_instr;
    logic            event_hit;
    logic            trail_active;

    modport master (
        output pc_valid, pc, instr,
        input  drop_instr, event_hit, trail_active
    );

    modport slave (
        input  pc_valid, pc, instr,
        output drop_instr, event_hit, trail_active
    );
endinterface
`default_nettype wire

// File: rtl/programmable_trace_filter.sv
`default_nettype none
// ============================================================================
// Module      : programmable_trace_filter
// Description : Runtime-programmable trace filter. It sits between the CPU
//               trace port and trace storage. Each valid instruction is
//               classified as branch, jump or WFI and checked against a class
//               mask and an optional PC window. Matching instructions are kept,
//               along with a programmable trail of the instructions that follow.
//               All other instructions are dropped. The block also keeps
//               saturating kept/dropped statistics.
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   tr             trace-port interface (slave modport)
//   cfg_wr         one-cycle strobe that latches all cfg_* fields
//   cfg_class_mask [0] branch [1] jump [2] WFI [3] every instruction
//   cfg_trail_len  instructions kept after each event
//   cfg_range_en   restrict the filter to pc_lo <= pc <= pc_hi
//   cfg_pc_lo/hi   inclusive PC window bounds
//   stats_clear    clear both statistics counters
//   kept_count     saturating count of kept valid instructions
//   dropped_count  saturating count of dropped valid instructions
// Revision    : 1.0 - initial release
// ============================================================================
module programmable_trace_filter #(
    parameter int XLEN          = 64,
    parameter int TRAIL_W       = 4,
    parameter int CNT_W         = 32,
    parameter int DEFAULT_TRAIL = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    programmable_trace_filter_if.slave tr,
    input  wire logic                  cfg_wr,
    input  wire logic [3:0]            cfg_class_mask,
    input  wire logic [TRAIL_W-1:0]    cfg_trail_len,
    input  wire logic                  cfg_range_en,
    input  wire logic [XLEN-1:0]       cfg_pc_lo,
    input  wire logic [XLEN-1:0]       cfg_pc_hi,
    input  wire logic                  stats_clear,
    output logic [CNT_W-1:0]           kept_count,
    output logic [CNT_W-1:0]           dropped_count
);

    // ------------------------------------------------------------------
    // Opcode constants
    // ------------------------------------------------------------------
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
    localparam logic [31:0] c_WFI_INSTR  = 32'h1050_0073;

    localparam logic [1:0]  c_Q_C1       = 2'b01;
    localparam logic [1:0]  c_Q_C2       = 2'b10;
    localparam logic [1:0]  c_Q_32       = 2'b11;
    localparam logic [2:0]  c_F3_CJAL    = 3'b001;
    localparam logic [2:0]  c_F3_CJ      = 3'b101;
    localparam logic [2:0]  c_F3_CBEQZ   = 3'b110;
    localparam logic [2:0]  c_F3_CBNEZ   = 3'b111;
    localparam logic [2:0]  c_F3_CJR     = 3'b100;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [3:0]         r_class_mask;
    logic [TRAIL_W-1:0] r_trail_len;
    logic               r_range_en;
    logic [XLEN-1:0]    r_pc_lo;
    logic [XLEN-1:0]    r_pc_hi;

    logic [TRAIL_W-1:0] r_trail_cnt;
    logic               r_trail_active;
    logic [CNT_W-1:0]   r_kept;
    logic [CNT_W-1:0]   r_dropped;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic [1:0] w_quad;
    logic [6:0] w_opc;
    logic [2:0] w_c_f3;
    logic [4:0] w_c_rs1;
    logic [4:0] w_c_rs2;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_is_wfi;
    logic [2:0] w_class;

    assign w_quad  = tr.instr[1:0];
    assign w_opc   = tr.instr[6:0];
    assign w_c_f3  = tr.instr[15:13];
    assign w_c_rs1 = tr.instr[11:7];
    assign w_c_rs2 = tr.instr[6:2];

    assign w_is_branch = ((w_quad == c_Q_32) && (w_opc == c_OPC_BRANCH)) ||
                         ((w_quad == c_Q_C1) &&
                          ((w_c_f3 == c_F3_CBEQZ) || (w_c_f3 == c_F3_CBNEZ)));

    // C.JR / C.JALR share funct3=100 with C.MV/C.ADD/C.EBREAK; they are the
    // encodings with rs2 == 0 and rs1 != 0, and bit 12 selects link or no link.
    assign w_is_jump = ((w_quad == c_Q_32) &&
                        ((w_opc == c_OPC_JAL) || (w_opc == c_OPC_JALR))) ||
                       ((w_quad == c_Q_C1) &&
                        ((w_c_f3 == c_F3_CJ) || (w_c_f3 == c_F3_CJAL))) ||
                       ((w_quad == c_Q_C2) && (w_c_f3 == c_F3_CJR) &&
                        (w_c_rs1 != 5'd0) && (w_c_rs2 == 5'd0));

    assign w_is_wfi = (tr.instr == c_WFI_INSTR);

    assign w_class = {w_is_wfi, w_is_jump, w_is_branch};

    // ------------------------------------------------------------------
    // Window, event and keep/drop decision (zero latency)
    // ------------------------------------------------------------------
    logic w_in_range;
    logic w_visible;
    logic w_event;
    logic w_trail_nz;
    logic w_keep;

    // An inverted window (lo > hi) can never satisfy both compares, so
    // nothing is visible in that case.
    assign w_in_range = !r_range_en ||
                        ((tr.pc >= r_pc_lo) && (tr.pc <= r_pc_hi));
    assign w_visible  = tr.pc_valid && w_in_range;
    assign w_event    = w_visible &&
                        (r_class_mask[3] || ((w_class & r_class_mask[2:0]) != 3'b000));
    assign w_trail_nz = (r_trail_cnt != '0);
    assign w_keep     = w_visible && (w_event || w_trail_nz);

    assign tr.event_hit    = w_event;
    assign tr.drop_instr   = !w_keep;
    assign tr.trail_active = r_trail_active;

    // ------------------------------------------------------------------
    // Trail counter next state
    // Out-of-window instructions leave the trail untouched. A new event
    // reloads the counter rather than adding to it. A config write
    // abandons any trail in progress.
    // ------------------------------------------------------------------
    logic [TRAIL_W-1:0] w_trail_nxt;

    always_comb begin
        w_trail_nxt = r_trail_cnt;
        if (cfg_wr) begin
            w_trail_nxt = '0;
        end else if (w_visible) begin
            if (w_event) begin
                w_trail_nxt = r_trail_len;
            end else if (w_trail_nz) begin
                w_trail_nxt = r_trail_cnt - TRAIL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration and trail state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_class_mask   <= 4'b0111;
            r_trail_len    <= TRAIL_W'(DEFAULT_TRAIL);
            r_range_en     <= 1'b0;
            r_pc_lo        <= '0;
            r_pc_hi        <= '1;
            r_trail_cnt    <= '0;
            r_trail_active <= 1'b0;
        end else begin
            if (cfg_wr) begin
                r_class_mask <= cfg_class_mask;
                r_trail_len  <= cfg_trail_len;
                r_range_en   <= cfg_range_en;
                r_pc_lo      <= cfg_pc_lo;
                r_pc_hi      <= cfg_pc_hi;
            end
            r_trail_cnt    <= w_trail_nxt;
            r_trail_active <= (w_trail_nxt != '0);
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
            r_kept    <= '0;
            r_dropped <= '0;
        end else if (tr.pc_valid) begin
            if (w_keep) begin
                if (r_kept != c_CNT_MAX) begin
                    r_kept <= r_kept + CNT_W'(1);
                end
            end else begin
                if (r_dropped != c_CNT_MAX) begin
                    r_dropped <= r_dropped + CNT_W'(1);
                end
            end
        end
    end

    assign kept_count    = r_kept;
    assign dropped_count = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_programmable_trace_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_programmable_trace_filter
// Description : Scoreboard bench for programmable_trace_filter. The stimulus
//               thread queues the expected drop/event response for every valid
//               instruction it issues. A monitor pops the queue and compares it
//               against the DUT on each falling edge where pc_valid is high.
//               The statistics counters are compared directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_programmable_trace_filter;

    localparam int XLEN    = 64;
    localparam int TRAIL_W = 4;
    localparam int CNT_W   = 4;

    localparam logic [31:0] c_BEQ   = 32'h0000_0063;
    localparam logic [31:0] c_BNE   = 32'h0000_1063;
    localparam logic [31:0] c_ADD   = 32'h0010_80B3;
    localparam logic [31:0] c_JAL   = 32'h0000_006F;
    localparam logic [31:0] c_JALR  = 32'h0000_8067;
    localparam logic [31:0] c_WFI   = 32'h1050_0073;
    localparam logic [31:0] c_CJ    = 32'h0000_A001;
    localparam logic [31:0] c_CJR0  = 32'h0000_8002;
    localparam logic [31:0] c_CJR1  = 32'h0000_8082;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_wr;
    logic [3:0]         cfg_class_mask;
    logic [TRAIL_W-1:0] cfg_trail_len;
    logic               cfg_range_en;
    logic [XLEN-1:0]    cfg_pc_lo;
    logic [XLEN-1:0]    cfg_pc_hi;
    logic               stats_clear;
    logic [CNT_W-1:0]   kept_count;
    logic [CNT_W-1:0]   dropped_count;

    programmable_trace_filter_if #(.XLEN(XLEN)) tif ();

    programmable_trace_filter #(
        .XLEN          (XLEN),
        .TRAIL_W       (TRAIL_W),
        .CNT_W         (CNT_W),
        .DEFAULT_TRAIL (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tr             (tif),
        .cfg_wr         (cfg_wr),
        .cfg_class_mask (cfg_class_mask),
        .cfg_trail_len  (cfg_trail_len),
        .cfg_range_en   (cfg_range_en),
        .cfg_pc_lo      (cfg_pc_lo),
        .cfg_pc_hi      (cfg_pc_hi),
        .stats_clear    (stats_clear),
        .kept_count     (kept_count),
        .dropped_count  (dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  drop;
        logic  hit;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one expected entry per valid instruction presented to the DUT.
    always @(negedge clk) begin
        if (!rst && tif.pc_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got valid instr, expected none queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.tag, ".drop"}, 64'(tif.drop_instr), 64'(e.drop));
                chk({e.tag, ".hit"},  64'(tif.event_hit),  64'(e.hit));
            end
        end
    end

    // Drive one cycle of stimulus just after the rising edge.
    task automatic step(input string tag, input logic v, input logic [XLEN-1:0] p,
                        input logic [31:0] ins, input logic wr, input logic clr,
                        input logic ed, input logic eh);
        exp_t e;
        @(posedge clk);
        #1;
        tif.pc_valid = v;
        tif.pc       = p;
        tif.instr    = ins;
        cfg_wr       = wr;
        stats_clear  = clr;
        if (v) begin
            e.drop = ed;
            e.hit  = eh;
            e.tag  = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        step("idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Program the filter and clear the statistics in the same cycle.
    task automatic cfg(input logic [3:0] m, input logic [TRAIL_W-1:0] t, input logic ren,
                       input logic [XLEN-1:0] lo, input logic [XLEN-1:0] hi);
        cfg_class_mask = m;
        cfg_trail_len  = t;
        cfg_range_en   = ren;
        cfg_pc_lo      = lo;
        cfg_pc_hi      = hi;
        step("cfg", 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Reset with a conflicting cfg_wr/stats_clear to show reset dominates.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        tif.pc_valid   = 1'b0;
        cfg_wr         = 1'b1;
        stats_clear    = 1'b1;
        cfg_class_mask = 4'b0000;
        cfg_trail_len  = 4'd9;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        cfg_wr      = 1'b0;
        stats_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        tif.pc_valid   = 1'b0;
        tif.pc         = '0;
        tif.instr      = '0;
        cfg_wr         = 1'b0;
        cfg_class_mask = '0;
        cfg_trail_len  = '0;
        cfg_range_en   = 1'b0;
        cfg_pc_lo      = '0;
        cfg_pc_hi      = '0;
        stats_clear    = 1'b0;
        do_reset();

        // ---- Reset state ----
        chk("rst.drop",    64'(tif.drop_instr),   64'd1);
        chk("rst.hit",     64'(tif.event_hit),    64'd0);
        chk("rst.trail",   64'(tif.trail_active), 64'd0);
        chk("rst.kept",    64'(kept_count),       64'd0);
        chk("rst.dropped", 64'(dropped_count),    64'd0);

        // ---- 1: defaults (mask 0111, trail 1) ----
        step("t1.beq",  1'b1, 64'h100, c_BEQ, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t1.add0", 1'b1, 64'h104, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1.add1", 1'b1, 64'h108, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t1.wfi",  1'b1, 64'h10C, c_WFI, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t1.add2", 1'b1, 64'h110, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t1.kept",    64'(kept_count),    64'd4);
        chk("t1.dropped", 64'(dropped_count), 64'd1);

        // ---- 2: trail 3, reload without accumulation ----
        cfg(4'b0111, 4'd3, 1'b0, '0, '1);
        step("t2.jal", 1'b1, 64'h200, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("t2.add_keep", 1'b1, 64'h204, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2.add_drop", 1'b1, 64'h210, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t2.jal_a", 1'b1, 64'h220, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t2.add_a", 1'b1, 64'h224, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2.jal_b", 1'b1, 64'h228, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("t2.add_rl", 1'b1, 64'h22C, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2.add_end", 1'b1, 64'h240, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t2.trail",   64'(tif.trail_active), 64'd0);
        chk("t2.kept",    64'(kept_count),       64'd10);
        chk("t2.dropped", 64'(dropped_count),    64'd2);

        // ---- 3: jump-only, no trail ----
        cfg(4'b0010, 4'd0, 1'b0, '0, '1);
        step("t3.bne",  1'b1, 64'h300, c_BNE,  1'b0, 1'b0, 1'b1, 1'b0);
        step("t3.cj",   1'b1, 64'h304, c_CJ,   1'b0, 1'b0, 1'b0, 1'b1);
        step("t3.cjr0", 1'b1, 64'h306, c_CJR0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t3.wfi",  1'b1, 64'h308, c_WFI,  1'b0, 1'b0, 1'b1, 1'b0);
        step("t3.cjr1", 1'b1, 64'h30C, c_CJR1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3.jalr", 1'b1, 64'h310, c_JALR, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3.add",  1'b1, 64'h314, c_ADD,  1'b0, 1'b0, 1'b1, 1'b0);

        // ---- 4: PC window 0x1000..0x1FFF, trail 2 ----
        cfg(4'b0111, 4'd2, 1'b1, 64'h1000, 64'h1FFF);
        step("t4.jal_lo",  1'b1, 64'h1000, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t4.add_out", 1'b1, 64'h3000, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t4.add_a",   1'b1, 64'h1004, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4.trail_held", 64'(tif.trail_active), 64'd1);
        step("t4.add_b",   1'b1, 64'h1008, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4.add_c",   1'b1, 64'h100C, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t4.jal_out", 1'b1, 64'h2000, c_JAL, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t4.jal_hi",  1'b1, 64'h1FFF, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t4.add_low", 1'b1, 64'h0FFF, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- 5: cfg_wr mid-trail, inverted window ----
        cfg(4'b0111, 4'd3, 1'b0, '0, '1);
        step("t5.jal", 1'b1, 64'h1800, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_class_mask = 4'b0111;
        cfg_trail_len  = 4'd3;
        cfg_range_en   = 1'b1;
        cfg_pc_lo      = 64'h2000;
        cfg_pc_hi      = 64'h1000;
        step("t5.add_wr",  1'b1, 64'h1800, c_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5.add_inv", 1'b1, 64'h1800, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5.trail_cleared", 64'(tif.trail_active), 64'd0);
        step("t5.jal_2000", 1'b1, 64'h2000, c_JAL, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t5.jal_1000", 1'b1, 64'h1000, c_JAL, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- 6: saturation, stats_clear, reset mid-trail ----
        cfg(4'b1000, 4'd0, 1'b0, '0, '1);
        for (int i = 0; i < 20; i++)
            step("t6.add_all", 1'b1, 64'h400, c_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t6.kept_sat", 64'(kept_count),    64'd15);
        chk("t6.dropped",  64'(dropped_count), 64'd0);
        step("t6.add_clr", 1'b1, 64'h400, c_ADD, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("t6.kept_clr",    64'(kept_count),    64'd0);
        chk("t6.dropped_clr", 64'(dropped_count), 64'd0);

        cfg(4'b0111, 4'd5, 1'b0, '0, '1);
        step("t6.jal", 1'b1, 64'h500, c_JAL, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t6.add", 1'b1, 64'h504, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("t6.rst_trail",   64'(tif.trail_active), 64'd0);
        chk("t6.rst_drop",    64'(tif.drop_instr),   64'd1);
        chk("t6.rst_kept",    64'(kept_count),       64'd0);
        chk("t6.rst_dropped", 64'(dropped_count),    64'd0);
        step("t6.add_post", 1'b1, 64'h508, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t6.beq_def",  1'b1, 64'h50C, c_BEQ, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t6.add_tr",   1'b1, 64'h510, c_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6.add_end",  1'b1, 64'h514, c_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t6.kept_end",    64'(kept_count),    64'd2);
        chk("t6.dropped_end", 64'(dropped_count), 64'd2);

        idle();
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
